gated_dreg_pipe: RTL and testbench
==================================

// Module: gated_dreg_pipe
// PURPOSE
//   Multi-channel gated D-register delay line with clear: CH independent lanes, each a
//   DEPTH-stage WIDTH-bit shift pipeline that advances only while its gate is high.
//   Per-stage valid tracking and an occupancy count per lane. Sits between producers and
//   consumers that need aligned, stallable, clearable storage of data samples.
// PARAMETERS
//   WIDTH    8   data bits per lane
//   CH       4   number of independent lanes
//   DEPTH    3   stages per lane (>=1); lane latency in gated cycles
//   CLR_VAL  0   value loaded into every data stage on clear (WIDTH bits)
// PORTS
//   clk    in   1                    rising-edge clock
//   clr    in   1                    asynchronous reset, active-high; all state to clear values
//   sclr   in   1                    synchronous clear, all lanes
//   d      in   CH*WIDTH             lane data in; lane c = d[c*WIDTH +: WIDTH]
//   d_vld  in   CH                   lane input sample valid
//   g      in   CH                   lane gate: 1 = advance on this edge, 0 = hold
//   q      out  CH*WIDTH             lane data out = last stage of lane (registered)
//   q_vld  out  CH                   valid of last stage of lane
//   occ    out  CH*CW                per-lane count of valid stages, CW=$clog2(DEPTH+1)
// BEHAVIOUR
//   - Clock: one domain, clk. Reset: clr async, active-high.
//   - clr=1 (async, any time): all data stages=CLR_VAL, all valid=0; hence q=CLR_VAL,
//     q_vld=0, occ=0 immediately, held while clr=1. First update on first clk edge after
//     clr falls.
//   - Priority per edge: clr > sclr > g. sclr=1: same clear as clr but on the edge;
//     d/d_vld on that edge discarded even if g=1.
//   - Lane c, g[c]=1: stage0<=d_c, vld0<=d_vld[c]; stage k<=stage k-1, vldk<=vld k-1.
//     Data shifts regardless of valid (invalid stages carry don't-care but deterministic data).
//   - Lane c, g[c]=0: all stages and valids of lane c hold; other lanes unaffected.
//   - Latency: sample with d_vld=1 accepted on edge E appears at q with q_vld=1 after
//     DEPTH edges with g[c]=1 (counting E). Stalls stretch latency, never drop/duplicate.
//   - Output sample leaves lane when g[c]=1 (overwritten); no backpressure beyond g.
//   - occ_c = popcount of lane c valid bits; combinational from valid regs, so it changes
//     on the same edge as the stages. Range 0..DEPTH; never wraps.
//   - DEPTH=1: lane is a single gated D flop with valid; occ is 1 bit.
//   - Boundary: full lane (occ=DEPTH) with g=1 and d_vld=1: occ stays DEPTH (one out,
//     one in). Empty lane with g=1, d_vld=0: occ stays 0.
//   - No combinational path from d/d_vld/g to q/q_vld/occ.
// TESTING
//   1 Reset: clr=1 mid-traffic -> q=CLR_VAL, q_vld=0, occ=0 without clk edge; held.
//   2 Latency, W=8,D=3: lane0 g=1 always, d=0x11,0x22,0x33 vld=1 on edges 1..3 ->
//     q=0x11 q_vld=1 after edge 3, 0x22 after 4, 0x33 after 5; occ 1,2,3,3,2(vld=0 in).
//   3 Stall: lane1 loaded with 0xA5, g[1]=0 for 5 cycles -> lane1 q/occ frozen while
//     lane0 keeps advancing; resume g[1]=1 -> 0xA5 emerges after remaining stages only.
//   4 sclr with g=1,d_vld=1,d=0xFF on all lanes -> next edge all occ=0, q=CLR_VAL,
//     0xFF never appears at q.
//   5 Full lane steady stream (occ=DEPTH, g=1, vld=1) -> occ stays DEPTH, q in order.
//   6 Bubbles: alternate d_vld 1/0 with g=1 -> q_vld alternates after DEPTH edges, occ
//     toggles between counts matching valid-bit popcount.

Source files
------------

// File: rtl/gated_dreg_pipe.sv
`default_nettype none
// ============================================================================
// Module      : gated_dreg_pipe
// Description : CH-lane gated D-register delay line; each lane is a DEPTH-stage
//               WIDTH-bit shift pipe with per-stage valid and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module gated_dreg_pipe #(
    parameter int unsigned       WIDTH   = 8,
    parameter int unsigned       CH      = 4,
    parameter int unsigned       DEPTH   = 3,
    parameter logic [WIDTH-1:0]  CLR_VAL = '0,
    localparam int unsigned      CW      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  sclr,
    input  logic [CH*WIDTH-1:0]   d,
    input  logic [CH-1:0]         d_vld,
    input  logic [CH-1:0]         g,
    output logic [CH*WIDTH-1:0]   q,
    output logic [CH-1:0]         q_vld,
    output logic [CH*CW-1:0]      occ
);

    logic [CH-1:0][DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [CH-1:0][DEPTH-1:0]            vld_q,  vld_d;

    // Data shifts with the gate whether or not the sample is valid, so invalid
    // stages always hold a deterministic value.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (sclr) begin
            data_d = {(CH*DEPTH){CLR_VAL}};
            vld_d  = '0;
        end else begin
            for (int c = 0; c < int'(CH); c++) begin
                if (g[c]) begin
                    data_d[c][0] = d[c*WIDTH +: WIDTH];
                    vld_d[c][0]  = d_vld[c];
                    for (int k = 1; k < int'(DEPTH); k++) begin
                        data_d[c][k] = data_q[c][k-1];
                        vld_d[c][k]  = vld_q[c][k-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            data_q <= {(CH*DEPTH){CLR_VAL}};
            vld_q  <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    generate
        for (genvar c = 0; c < int'(CH); c++) begin : g_lane
            logic [CW-1:0] cnt;

            always_comb begin
                cnt = '0;
                for (int k = 0; k < int'(DEPTH); k++) begin
                    cnt = cnt + CW'(vld_q[c][k]);
                end
            end

            assign q[c*WIDTH +: WIDTH] = data_q[c][DEPTH-1];
            assign q_vld[c]            = vld_q[c][DEPTH-1];
            assign occ[c*CW +: CW]     = cnt;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_gated_dreg_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_gated_dreg_pipe
// Description : Randomized self-checking bench for gated_dreg_pipe against a
//               per-lane queue model (push new sample, drop oldest on gate).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gated_dreg_pipe;

    localparam int         W     = 8;
    localparam int         CH    = 4;
    localparam int         DEPTH = 3;
    localparam int         CW    = $clog2(DEPTH + 1);
    localparam logic [W-1:0] CLRV = 8'h00;

    logic              clk = 1'b0;
    logic              clr;
    logic              sclr;
    logic [CH*W-1:0]   d;
    logic [CH-1:0]     d_vld;
    logic [CH-1:0]     g;
    logic [CH*W-1:0]   q;
    logic [CH-1:0]     q_vld;
    logic [CH*CW-1:0]  occ;

    int n_vec = 0;
    int n_err = 0;

    // Lane model: index 0 is the newest sample, index DEPTH-1 is the output.
    logic [W-1:0] mdat [CH][$];
    logic         mvld [CH][$];

    always #5 clk = ~clk;

    gated_dreg_pipe #(
        .WIDTH   (W),
        .CH      (CH),
        .DEPTH   (DEPTH),
        .CLR_VAL (CLRV)
    ) u_dut (
        .clk   (clk),
        .clr   (clr),
        .sclr  (sclr),
        .d     (d),
        .d_vld (d_vld),
        .g     (g),
        .q     (q),
        .q_vld (q_vld),
        .occ   (occ)
    );

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            mdat[c].delete();
            mvld[c].delete();
            for (int k = 0; k < DEPTH; k++) begin
                mdat[c].push_back(CLRV);
                mvld[c].push_back(1'b0);
            end
        end
    endtask

    task automatic model_edge();
        if (clr || sclr) begin
            model_reset();
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (g[c]) begin
                    mdat[c].push_front(d[c*W +: W]);
                    mvld[c].push_front(d_vld[c]);
                    void'(mdat[c].pop_back());
                    void'(mvld[c].pop_back());
                end
            end
        end
    endtask

    function automatic logic [W-1:0] exp_q(int c);
        return mdat[c][DEPTH-1];
    endfunction

    function automatic logic exp_v(int c);
        return mvld[c][DEPTH-1];
    endfunction

    function automatic logic [CW-1:0] exp_occ(int c);
        int s = 0;
        for (int k = 0; k < DEPTH; k++) s += int'(mvld[c][k]);
        return CW'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_data();
        for (int c = 0; c < CH; c++) d[c*W +: W] = W'($urandom);
    endtask

    task automatic test_reset();
        clr = 1'b1; sclr = 1'b0; d = '0; d_vld = '0; g = '0;
        model_reset();
        #7;
        for (int c = 0; c < CH; c++) begin
            n_vec++;
            if (q[c*W +: W] !== CLRV || q_vld[c] !== 1'b0 || occ[c*CW +: CW] !== '0) begin
                n_err++;
                $display("FAIL reset_init lane %0d: got q=%h vld=%b occ=%0d, want q=%h vld=0 occ=0",
                         c, q[c*W +: W], q_vld[c], occ[c*CW +: CW], CLRV);
            end
        end
        @(posedge clk); #1;
        clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_data();
            d_vld = '1;
            g = CH'($urandom) | CH'(1);
            tick();
        end
        g = '0;
        #3;
        clr = 1'b1;
        #1;
        for (int c = 0; c < CH; c++) begin
            n_vec++;
            if (q[c*W +: W] !== CLRV || q_vld[c] !== 1'b0 || occ[c*CW +: CW] !== '0) begin
                n_err++;
                $display("FAIL reset_async lane %0d: got q=%h vld=%b occ=%0d, want q=%h vld=0 occ=0",
                         c, q[c*W +: W], q_vld[c], occ[c*CW +: CW], CLRV);
            end
        end
        g = '1; d_vld = '1; rand_data();
        tick();
        tick();
        for (int c = 0; c < CH; c++) begin
            n_vec++;
            if (q[c*W +: W] !== CLRV || q_vld[c] !== 1'b0 || occ[c*CW +: CW] !== '0) begin
                n_err++;
                $display("FAIL reset_held lane %0d: got q=%h vld=%b occ=%0d, want q=%h vld=0 occ=0",
                         c, q[c*W +: W], q_vld[c], occ[c*CW +: CW], CLRV);
            end
        end
        clr = 1'b0; g = '0; d_vld = '0;
        model_reset();
    endtask

    task automatic test_latency();
        logic [W-1:0]  din  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic          vin  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [CW-1:0] eocc [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2};
        logic          ev   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [W-1:0]  eq   [5] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
        g = 4'b0001; d = '0; d_vld = '0;
        for (int i = 0; i < 5; i++) begin
            d[W-1:0] = din[i];
            d_vld[0] = vin[i];
            tick();
            n_vec++;
            if (q[W-1:0] !== eq[i] || q_vld[0] !== ev[i] || occ[CW-1:0] !== eocc[i]) begin
                n_err++;
                $display("FAIL latency edge %0d: got q=%h vld=%b occ=%0d, want q=%h vld=%b occ=%0d",
                         i + 1, q[W-1:0], q_vld[0], occ[CW-1:0], eq[i], ev[i], eocc[i]);
            end
            for (int c = 1; c < CH; c++) begin
                n_vec++;
                if (occ[c*CW +: CW] !== '0 || q_vld[c] !== 1'b0) begin
                    n_err++;
                    $display("FAIL latency_idle lane %0d edge %0d: got vld=%b occ=%0d, want vld=0 occ=0",
                             c, i + 1, q_vld[c], occ[c*CW +: CW]);
                end
            end
        end
    endtask

    task automatic test_stall();
        sclr = 1'b1; g = '0; d_vld = '0;
        tick();
        sclr = 1'b0;
        g = 4'b0010; d_vld = 4'b0010; d = '0; d[W +: W] = 8'hA5;
        tick();
        for (int i = 0; i < 5; i++) begin
            g = 4'b0001; d_vld = CH'($urandom); rand_data();
            tick();
            n_vec++;
            if (q[W +: W] !== CLRV || q_vld[1] !== 1'b0 || occ[CW +: CW] !== CW'(1)) begin
                n_err++;
                $display("FAIL stall_frozen cycle %0d: got q=%h vld=%b occ=%0d, want q=%h vld=0 occ=1",
                         i, q[W +: W], q_vld[1], occ[CW +: CW], CLRV);
            end
            n_vec++;
            if (q[W-1:0] !== exp_q(0) || q_vld[0] !== exp_v(0) || occ[CW-1:0] !== exp_occ(0)) begin
                n_err++;
                $display("FAIL stall_lane0 cycle %0d: got q=%h vld=%b occ=%0d, want q=%h vld=%b occ=%0d",
                         i, q[W-1:0], q_vld[0], occ[CW-1:0], exp_q(0), exp_v(0), exp_occ(0));
            end
        end
        for (int i = 1; i < DEPTH; i++) begin
            g = 4'b0011; d_vld = 4'b0000; rand_data();
            tick();
            n_vec++;
            if (q_vld[1] !== (i == DEPTH - 1) || (i == DEPTH - 1 && q[W +: W] !== 8'hA5)) begin
                n_err++;
                $display("FAIL stall_resume step %0d: got q=%h vld=%b, want vld=%b (A5 on last step)",
                         i, q[W +: W], q_vld[1], (i == DEPTH - 1));
            end
        end
    endtask

    task automatic test_sclr();
        for (int i = 0; i < 8; i++) begin
            g = '1; d_vld = CH'($urandom); rand_data();
            tick();
        end
        sclr = 1'b1; g = '1; d_vld = '1; d = '1;
        tick();
        sclr = 1'b0;
        for (int c = 0; c < CH; c++) begin
            n_vec++;
            if (q[c*W +: W] !== CLRV || q_vld[c] !== 1'b0 || occ[c*CW +: CW] !== '0) begin
                n_err++;
                $display("FAIL sclr lane %0d: got q=%h vld=%b occ=%0d, want q=%h vld=0 occ=0",
                         c, q[c*W +: W], q_vld[c], occ[c*CW +: CW], CLRV);
            end
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            g = '1; d_vld = '0;
            for (int c = 0; c < CH; c++) d[c*W +: W] = W'($urandom_range(0, 254));
            tick();
            for (int c = 0; c < CH; c++) begin
                n_vec++;
                if (q[c*W +: W] === 8'hFF || q_vld[c] !== 1'b0 || occ[c*CW +: CW] !== '0) begin
                    n_err++;
                    $display("FAIL sclr_discard lane %0d step %0d: got q=%h vld=%b occ=%0d, want q!=ff vld=0 occ=0",
                             c, i, q[c*W +: W], q_vld[c], occ[c*CW +: CW]);
                end
            end
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH + 12; i++) begin
            g = '1; d_vld = '1; rand_data();
            tick();
            for (int c = 0; c < CH; c++) begin
                n_vec++;
                if (q[c*W +: W] !== exp_q(c) || q_vld[c] !== exp_v(c) || occ[c*CW +: CW] !== exp_occ(c)
                    || (i >= DEPTH - 1 && occ[c*CW +: CW] !== CW'(DEPTH))) begin
                    n_err++;
                    $display("FAIL full lane %0d step %0d: got q=%h vld=%b occ=%0d, want q=%h vld=%b occ=%0d",
                             c, i, q[c*W +: W], q_vld[c], occ[c*CW +: CW], exp_q(c), exp_v(c), exp_occ(c));
                end
            end
        end
    endtask

    task automatic test_bubbles();
        for (int i = 0; i < 12; i++) begin
            g = '1; d_vld = (i % 2 == 0) ? '1 : '0; rand_data();
            tick();
            for (int c = 0; c < CH; c++) begin
                n_vec++;
                if (q[c*W +: W] !== exp_q(c) || q_vld[c] !== exp_v(c) || occ[c*CW +: CW] !== exp_occ(c)
                    || (i >= DEPTH - 1 && q_vld[c] !== ((i - DEPTH + 1) % 2 == 0))) begin
                    n_err++;
                    $display("FAIL bubbles lane %0d step %0d: got q=%h vld=%b occ=%0d, want q=%h vld=%b occ=%0d",
                             c, i, q[c*W +: W], q_vld[c], occ[c*CW +: CW], exp_q(c), exp_v(c), exp_occ(c));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            g = CH'($urandom); d_vld = CH'($urandom); rand_data();
            sclr = ($urandom_range(0, 19) == 0);
            tick();
            for (int c = 0; c < CH; c++) begin
                n_vec++;
                if (q[c*W +: W] !== exp_q(c) || q_vld[c] !== exp_v(c) || occ[c*CW +: CW] !== exp_occ(c)) begin
                    n_err++;
                    $display("FAIL random lane %0d step %0d: got q=%h vld=%b occ=%0d, want q=%h vld=%b occ=%0d",
                             c, i, q[c*W +: W], q_vld[c], occ[c*CW +: CW], exp_q(c), exp_v(c), exp_occ(c));
                end
            end
        end
        sclr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_sclr();
        test_full();
        test_bubbles();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
